// File: rtl/altera_mem_if_ddr2_phy_0001_qsys_sequencer_pkg.sv
// Sequencer RAM loader shared definitions.
// State encoding, RAM geometry and Avalon byte-enable constant.
package altera_mem_if_ddr2_phy_0001_qsys_sequencer_pkg;

   localparam int SEQ_DEPTH  = 512;
   localparam int SEQ_ADDR_W = 9;

   localparam logic [3:0] BE_ALL = 4'hF;

   typedef enum logic [2:0] {
      S_LOAD,
      S_VERIFY,
      S_DRAIN,
      S_COMPARE,
      S_RUN,
      S_ERROR
   } state_t;

endpackage

// File: rtl/altera_mem_if_ddr2_phy_0001_qsys_sequencer_ram_mux.sv
// Combinational RAM-port mux: loader write, verify read or CPU pass-through.
// Ports: state_i selects the source; ld_*/vf_*/cpu_* sources; ram_*_o to RAM.
module altera_mem_if_ddr2_phy_0001_qsys_sequencer_ram_mux
   import altera_mem_if_ddr2_phy_0001_qsys_sequencer_pkg::*;
#(
   parameter int ADDR_W = SEQ_ADDR_W
) (
   input  state_t              state_i,
   input  logic [ADDR_W-1:0]   ld_addr_i,
   input  logic                ld_wr_i,
   input  logic [31:0]         ld_data_i,
   input  logic [ADDR_W-1:0]   vf_addr_i,
   input  logic [ADDR_W-1:0]   cpu_address_i,
   input  logic [3:0]          cpu_byteenable_i,
   input  logic                cpu_chipselect_i,
   input  logic                cpu_write_i,
   input  logic [31:0]         cpu_writedata_i,
   output logic [ADDR_W-1:0]   ram_address_o,
   output logic [3:0]          ram_byteenable_o,
   output logic                ram_chipselect_o,
   output logic                ram_write_o,
   output logic [31:0]         ram_writedata_o
);

   always_comb begin
      ram_address_o    = '0;
      ram_byteenable_o = BE_ALL;
      ram_chipselect_o = 1'b0;
      ram_write_o      = 1'b0;
      ram_writedata_o  = '0;
      unique case (state_i)
         S_LOAD: begin
            ram_address_o    = ld_addr_i;
            ram_chipselect_o = ld_wr_i;
            ram_write_o      = ld_wr_i;
            ram_writedata_o  = ld_data_i;
         end
         S_VERIFY: begin
            ram_address_o    = vf_addr_i;
            ram_chipselect_o = 1'b1;
         end
         S_RUN: begin
            ram_address_o    = cpu_address_i;
            ram_byteenable_o = cpu_byteenable_i;
            ram_chipselect_o = cpu_chipselect_i;
            ram_write_o      = cpu_write_i;
            ram_writedata_o  = cpu_writedata_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/blk_2afd55.sv
// Sequencer RAM boot loader: streams the program into RAM, checks a
// read-back sum, then releases the CPU and hands it the RAM port.
// Ports: load_* host stream, cpu_* Avalon slave side, ram_* RAM master
// side, cpu_reset_n / load_done / load_error / word_count status.
module blk_2afd55
   import altera_mem_if_ddr2_phy_0001_qsys_sequencer_pkg::*;
#(
   parameter int DEPTH  = SEQ_DEPTH,
   parameter int ADDR_W = SEQ_ADDR_W,
   parameter bit VERIFY = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [31:0]       load_data,
   input  logic              load_last,
   input  logic              reload,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic [3:0]        cpu_byteenable,
   input  logic              cpu_chipselect,
   input  logic              cpu_write,
   input  logic [31:0]       cpu_writedata,
   output logic [31:0]       cpu_readdata,
   output logic              cpu_waitrequest,
   output logic [ADDR_W-1:0] ram_address,
   output logic [3:0]        ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [31:0]       ram_writedata,
   output logic              ram_clken,
   input  logic [31:0]       ram_readdata,
   output logic              cpu_reset_n,
   output logic              load_done,
   output logic              load_error,
   output logic [ADDR_W:0]   word_count
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   wc_q, wc_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic [31:0]       sum_q, sum_d;
   logic [31:0]       chk_q, chk_d;

   logic hs;
   logic full;
   logic last_rd;

   assign load_ready = reset_n && (state_q == S_LOAD);
   assign hs         = load_valid && load_ready;
   assign full       = (wc_q == FULL_CNT);
   assign last_rd    = ({1'b0, rd_q} == (wc_q - 1'b1));

   always_comb begin
      state_d = state_q;
      wc_d    = wc_q;
      rd_d    = rd_q;
      sum_d   = sum_q;
      chk_d   = chk_q;
      unique case (state_q)
         S_LOAD: begin
            if (hs) begin
               if (full) begin
                  state_d = S_ERROR;
               end else begin
                  wc_d  = wc_q + 1'b1;
                  sum_d = sum_q + load_data;
                  if (load_last) begin
                     state_d = VERIFY ? S_VERIFY : S_RUN;
                     rd_d    = '0;
                     chk_d   = '0;
                  end
               end
            end
         end
         S_VERIFY: begin
            // Read data lags its address by one cycle; the first
            // cycle has nothing to accumulate yet.
            if (rd_q != '0)
               chk_d = chk_q + ram_readdata;
            if (last_rd)
               state_d = S_DRAIN;
            else
               rd_d = rd_q + 1'b1;
         end
         S_DRAIN: begin
            chk_d   = chk_q + ram_readdata;
            state_d = S_COMPARE;
         end
         S_COMPARE: begin
            state_d = (chk_q == sum_q) ? S_RUN : S_ERROR;
         end
         S_RUN, S_ERROR: begin
            if (reload) begin
               state_d = S_LOAD;
               wc_d    = '0;
               sum_d   = '0;
               chk_d   = '0;
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_LOAD;
         wc_q    <= '0;
         rd_q    <= '0;
         sum_q   <= '0;
         chk_q   <= '0;
      end else begin
         state_q <= state_d;
         wc_q    <= wc_d;
         rd_q    <= rd_d;
         sum_q   <= sum_d;
         chk_q   <= chk_d;
      end
   end

   assign cpu_reset_n     = (state_q == S_RUN);
   assign load_done       = (state_q == S_RUN);
   assign load_error      = (state_q == S_ERROR);
   assign cpu_waitrequest = (state_q != S_RUN);
   assign word_count      = wc_q;
   assign cpu_readdata    = ram_readdata;
   assign ram_clken       = 1'b1;

   altera_mem_if_ddr2_phy_0001_qsys_sequencer_ram_mux #(
      .ADDR_W (ADDR_W)
   ) u_mux (
      .state_i          (state_q),
      .ld_addr_i        (wc_q[ADDR_W-1:0]),
      .ld_wr_i          (hs && !full),
      .ld_data_i        (load_data),
      .vf_addr_i        (rd_q),
      .cpu_address_i    (cpu_address),
      .cpu_byteenable_i (cpu_byteenable),
      .cpu_chipselect_i (cpu_chipselect),
      .cpu_write_i      (cpu_write),
      .cpu_writedata_i  (cpu_writedata),
      .ram_address_o    (ram_address),
      .ram_byteenable_o (ram_byteenable),
      .ram_chipselect_o (ram_chipselect),
      .ram_write_o      (ram_write),
      .ram_writedata_o  (ram_writedata)
   );

endmodule

// File: tb/tb_blk_2afd55.sv
// Bench for the sequencer RAM loader with a behavioural 512x32 RAM.
// Table vectors, directed corner cases and randomized loads vs a model.
module tb_blk_2afd55;

   localparam int DEPTH = 512;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_data;
   logic        load_last;
   logic        reload;
   logic [8:0]  cpu_address;
   logic [3:0]  cpu_byteenable;
   logic        cpu_chipselect;
   logic        cpu_write;
   logic [31:0] cpu_writedata;
   logic [31:0] cpu_readdata;
   logic        cpu_waitrequest;
   logic [8:0]  ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect;
   logic        ram_write;
   logic [31:0] ram_writedata;
   logic        ram_clken;
   logic [31:0] ram_readdata;
   logic        cpu_reset_n;
   logic        load_done;
   logic        load_error;
   logic [9:0]  word_count;

   int n_chk = 0;
   int n_err = 0;

   blk_2afd55 dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .load_valid      (load_valid),
      .load_ready      (load_ready),
      .load_data       (load_data),
      .load_last       (load_last),
      .reload          (reload),
      .cpu_address     (cpu_address),
      .cpu_byteenable  (cpu_byteenable),
      .cpu_chipselect  (cpu_chipselect),
      .cpu_write       (cpu_write),
      .cpu_writedata   (cpu_writedata),
      .cpu_readdata    (cpu_readdata),
      .cpu_waitrequest (cpu_waitrequest),
      .ram_address     (ram_address),
      .ram_byteenable  (ram_byteenable),
      .ram_chipselect  (ram_chipselect),
      .ram_write       (ram_write),
      .ram_writedata   (ram_writedata),
      .ram_clken       (ram_clken),
      .ram_readdata    (ram_readdata),
      .cpu_reset_n     (cpu_reset_n),
      .load_done       (load_done),
      .load_error      (load_error),
      .word_count      (word_count)
   );

   always #5 clk = ~clk;

   // behavioural RAM with optional read corruption
   logic [31:0] mem [0:DEPTH-1];
   logic [31:0] q;
   logic [8:0]  q_addr;
   logic [31:0] wmix;
   logic        flip_en;
   logic [8:0]  flip_addr;

   initial begin
      for (int i = 0; i < DEPTH; i++)
         mem[i] = 32'hA5A50000 | i;
      q = '0;
      q_addr = '0;
   end

   always @(posedge clk) begin
      if (ram_clken && ram_chipselect) begin
         if (ram_write) begin
            wmix = mem[ram_address];
            for (int b = 0; b < 4; b++)
               if (ram_byteenable[b])
                  wmix[8*b +: 8] = ram_writedata[8*b +: 8];
            mem[ram_address] <= wmix;
         end
         q      <= mem[ram_address];
         q_addr <= ram_address;
      end
   end

   assign ram_readdata =
      q ^ ((flip_en && q_addr == flip_addr) ? 32'h1 : 32'h0);

   // image being streamed (reference for the RAM contents)
   logic [31:0] img [0:DEPTH];

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        last;
      logic [9:0]  wc;
      logic        wr;
   } vec_t;

   vec_t tv [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic stream(input int n, input bit with_last,
                         input int gap);
      int i = 0;
      while (i < n) begin
         if ($urandom_range(0, 99) < gap) begin
            load_valid = 1'b0;
            tick();
         end else begin
            load_valid = 1'b1;
            load_data  = img[i];
            load_last  = with_last && (i == n - 1);
            #1;
            check("stream_ready", load_ready, 1);
            check("stream_wr", ram_write, (i < DEPTH) ? 1 : 0);
            if (i < DEPTH)
               check("stream_addr", ram_address, i[8:0]);
            tick();
            i++;
         end
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   // edges from the last handshake edge until RUN or ERROR
   task automatic wait_end(input int exp_edges, input string nm);
      int k = 1;
      while (!cpu_reset_n && !load_error && k < 2000) begin
         tick();
         k++;
      end
      check(nm, k, exp_edges);
   endtask

   task automatic check_img(input int n, input string nm);
      int bad = 0;
      for (int i = 0; i < n; i++)
         if (mem[i] !== img[i]) bad++;
      check(nm, bad, 0);
   endtask

   task automatic do_reload();
      reload = 1'b1;
      tick();
      reload = 1'b0;
      check("reload_ready", load_ready, 1);
      check("reload_wc", word_count, 0);
      check("reload_cpurst", cpu_reset_n, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n        = 1'b0;
      load_valid     = 1'b0;
      load_data      = '0;
      load_last      = 1'b0;
      reload         = 1'b0;
      cpu_address    = '0;
      cpu_byteenable = '0;
      cpu_chipselect = 1'b0;
      cpu_write      = 1'b0;
      cpu_writedata  = '0;
      flip_en        = 1'b0;
      flip_addr      = '0;

      // reset state
      repeat (2) tick();
      check("rst_ready", load_ready, 0);
      check("rst_cpurst", cpu_reset_n, 0);
      check("rst_done", load_done, 0);
      check("rst_err", load_error, 0);
      check("rst_wc", word_count, 0);
      check("rst_wait", cpu_waitrequest, 1);
      check("rst_cs", ram_chipselect, 0);
      check("rst_wr", ram_write, 0);
      reset_n = 1'b1;
      #1;
      check("post_rst_ready", load_ready, 1);

      // table: 4-word load with bubbles, verify enabled
      tv[0] = '{1'b1, 32'h11, 1'b0, 10'd0, 1'b1};
      tv[1] = '{1'b0, 32'h00, 1'b0, 10'd1, 1'b0};
      tv[2] = '{1'b1, 32'h22, 1'b0, 10'd1, 1'b1};
      tv[3] = '{1'b1, 32'h33, 1'b0, 10'd2, 1'b1};
      tv[4] = '{1'b0, 32'h00, 1'b0, 10'd3, 1'b0};
      tv[5] = '{1'b1, 32'h44, 1'b1, 10'd3, 1'b1};
      for (int i = 0; i < 6; i++) begin
         load_valid = tv[i].v;
         load_data  = tv[i].d;
         load_last  = tv[i].last;
         #1;
         check("tv_wc", word_count, tv[i].wc);
         check("tv_wr", ram_write, tv[i].wr);
         if (tv[i].wr)
            check("tv_addr", ram_address, tv[i].wc[8:0]);
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      wait_end(7, "t4_cpurst_latency");
      check("t4_cpurst", cpu_reset_n, 1);
      check("t4_done", load_done, 1);
      check("t4_err", load_error, 0);
      check("t4_wc", word_count, 4);
      check("t4_wait", cpu_waitrequest, 0);
      check("t4_ready", load_ready, 0);
      img[0] = 32'h11; img[1] = 32'h22;
      img[2] = 32'h33; img[3] = 32'h44;
      check_img(4, "t4_image");

      // CPU partial write then read in RUN
      cpu_chipselect = 1'b1;
      cpu_write      = 1'b1;
      cpu_address    = 9'd5;
      cpu_byteenable = 4'b0011;
      cpu_writedata  = 32'hDEADBEEF;
      #1;
      check("cpu_wait_run", cpu_waitrequest, 0);
      check("cpu_ram_wr", ram_write, 1);
      check("cpu_ram_addr", ram_address, 5);
      tick();
      cpu_write = 1'b0;
      tick();
      check("cpu_rdata", cpu_readdata, 32'hA5A5BEEF);
      cpu_chipselect = 1'b0;

      // reload from RUN; CPU access is then refused
      do_reload();
      check("rl_done", load_done, 0);
      cpu_chipselect = 1'b1;
      cpu_write      = 1'b1;
      cpu_address    = 9'd6;
      cpu_byteenable = 4'hF;
      cpu_writedata  = 32'h12345678;
      #1;
      check("rl_cpu_wait", cpu_waitrequest, 1);
      check("rl_ram_wr", ram_write, 0);
      tick();
      cpu_chipselect = 1'b0;
      cpu_write      = 1'b0;
      check("rl_mem6", mem[6], 32'hA5A50006);

      // reset in the middle of a load
      for (int i = 0; i < 3; i++) img[i] = $urandom;
      stream(3, 1'b0, 0);
      check("mid_wc", word_count, 3);
      reset_n = 1'b0;
      #1;
      check("mid_rst_ready", load_ready, 0);
      tick();
      reset_n = 1'b1;
      #1;
      check("mid_wc0", word_count, 0);
      check("mid_ready", load_ready, 1);

      // corrupted read-back at address 2; stream restarts at 0
      for (int i = 0; i < 4; i++) img[i] = $urandom;
      flip_en   = 1'b1;
      flip_addr = 9'd2;
      stream(4, 1'b1, 0);
      wait_end(7, "flip_latency");
      check("flip_err", load_error, 1);
      check("flip_cpurst", cpu_reset_n, 0);
      check("flip_done", load_done, 0);
      flip_en = 1'b0;
      do_reload();
      check("flip_rl_err", load_error, 0);

      // full 512-word image with last on the final word
      for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
      stream(DEPTH, 1'b1, 0);
      wait_end(DEPTH + 3, "full_latency");
      check("full_done", load_done, 1);
      check("full_err", load_error, 0);
      check("full_wc", word_count, DEPTH);
      check_img(DEPTH, "full_image");
      do_reload();

      // overflow: 513 words without last
      for (int i = 0; i <= DEPTH; i++) img[i] = $urandom;
      stream(DEPTH + 1, 1'b0, 0);
      check("ovf_err", load_error, 1);
      check("ovf_cpurst", cpu_reset_n, 0);
      check("ovf_mem0", mem[0], img[0]);
      do_reload();

      // randomized loads against the model
      for (int it = 0; it < 10; it++) begin
         int  n;
         bit  bad;
         logic [31:0] s_img;
         n   = $urandom_range(1, 24);
         bad = ($urandom_range(0, 2) == 0);
         s_img = '0;
         for (int i = 0; i < n; i++) begin
            img[i] = $urandom;
            s_img  = s_img + img[i];
         end
         flip_en   = bad;
         flip_addr = 9'($urandom_range(0, n - 1));
         stream(n, 1'b1, 30);
         wait_end(n + 3, "rnd_latency");
         check("rnd_err", load_error, bad);
         check("rnd_done", load_done, !bad);
         check("rnd_wc", word_count, n);
         check_img(n, "rnd_image");
         flip_en = 1'b0;
         do_reload();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/blk_2afd55.md
# altera_mem_if_ddr2_phy_0001_qsys_sequencer_ram_loader

Boot loader and port arbiter in front of the 512x32 sequencer RAM. Holds the sequencer CPU in reset, accepts the sequencer program as a stream of 32-bit words from the host link, writes them from address 0 upward and optionally reads them back to check a 32-bit sum. It then releases the CPU and hands it the RAM port. The block sits between the host stream and sequencer CPU on one side and the sequencer RAM slave on the other.

## Interface
- DEPTH, 512, RAM words; overflow limit
- ADDR_W, 9, RAM address width
- VERIFY, 1, 1 = read-back sum check after load; 0 = skip
- clk  in  1  sole clock; RAM runs on the same clock
- reset_n  in  1  synchronous, active-low reset
- load_valid / load_ready  in/out  1/1  host word handshake
- load_data  in  32  program word
- load_last  in  1  marks the final word of the image
- reload  in  1  one-cycle pulse; restart load from RUN or ERROR
- cpu_address  in  ADDR_W  CPU Avalon address
- cpu_byteenable  in  4  CPU Avalon byte enables
- cpu_chipselect, cpu_write  in  1  CPU Avalon controls
- cpu_writedata  in  32  CPU write data
- cpu_readdata  out  32  pass-through of ram_readdata
- cpu_waitrequest  out  1  high in every state except RUN
- ram_address  out  ADDR_W  to RAM
- ram_byteenable  out  4  to RAM
- ram_chipselect, ram_write  out  1  to RAM
- ram_writedata  out  32  to RAM
- ram_clken  out  1  tied 1
- ram_readdata  in  32  RAM q; valid the cycle after the address is presented
- cpu_reset_n  out  1  sequencer CPU reset; low until RUN
- load_done, load_error  out  1  status
- word_count  out  ADDR_W+1  words accepted in current load

## Operation
- States: LOAD, VERIFY, DRAIN, COMPARE, RUN, ERROR. Reset enters LOAD.
- Reset values: cpu_reset_n=0, load_done=0, load_error=0, word_count=0, load_ready=0 while reset_n=0, cpu_waitrequest=1, ram_chipselect=0, ram_write=0.
- LOAD:
  - load_ready=1.
  - Each handshake writes load_data to address word_count with byteenable 4'hF, adds it to sum (32-bit, mod 2^32), and increments word_count.
  - Handshake with load_last: go to VERIFY if VERIFY=1, otherwise RUN.
  - Handshake while word_count==DEPTH (a 513th word): go to ERROR; no write occurs.
- VERIFY: issue reads at addresses 0..word_count-1, one per cycle. Each ram_readdata is added into chk the following cycle.
- DRAIN: accumulate the final read word.
- COMPARE: chk==sum goes to RUN, otherwise ERROR.
- RUN:
  - RAM port muxed to the CPU combinationally.
  - cpu_reset_n=1, load_done=1.
  - load_ready=0; stream words are not accepted.
- ERROR: cpu_reset_n=0, load_error=1, load_ready=0, RAM idle.
- reload in RUN or ERROR:
  - Next cycle: LOAD, with word_count, sum, chk, load_done and load_error cleared and cpu_reset_n=0.
  - reload in any other state is ignored.
- RAM contents are never cleared; words beyond word_count keep stale data.

## Timing
- Load throughput: one word per cycle. ram_write is asserted in the handshake cycle (combinational from load_valid and state).
- Last handshake at cycle T, VERIFY=1, N words:
  - Read addresses at T+1..T+N.
  - DRAIN at T+N+1, COMPARE at T+N+2.
  - cpu_reset_n and load_done high from T+N+3.
- VERIFY=0: cpu_reset_n high from T+1.
- A CPU transaction is accepted only in RUN. Reads return data the following cycle, as the RAM delivers it.
- reset_n low in any state, including mid-load or mid-verify: LOAD next cycle with all reset values. A partially written image is abandoned.
- load_last on the 512th word is legal. load_last on the 513th is overflow → ERROR.

## Structure
- Shared package `altera_mem_if_ddr2_phy_0001_qsys_sequencer_pkg`: state encoding, DEPTH and ADDR_W constants, Avalon byte-enable-all constant.
- One natural sub-module: `altera_mem_if_ddr2_phy_0001_qsys_sequencer_ram_mux`, the combinational RAM-port mux selected by state.
- Everything else (FSM, counters, sums) lives in the top.

## Test plan
- Load 4 words 0x11,0x22,0x33,0x44 with last on the 4th, VERIFY=1 → RAM[0..3] match, cpu_reset_n rises exactly 7 cycles after the last handshake, load_error=0.
- Load 512 words with last on the 512th → RUN. Repeat with no last → the 513th word gives load_error=1 and RAM[0] is unchanged.
- Bench forces ram_readdata bit flip on verify address 2 → COMPARE fails, load_error=1, cpu_reset_n stays 0.
- In RUN, CPU writes 0xDEADBEEF with byteenable 4'b0011 to address 5, then reads it → low half updated, high half intact, cpu_waitrequest=0.
- reset_n low for 1 cycle after word 3 of a load → word_count=0, LOAD state, next stream writes start at address 0.
- reload pulse in RUN → cpu_reset_n=0 next cycle, load_ready=1. A CPU access attempted then sees cpu_waitrequest=1 and no RAM write.
